vending_sequencer: RTL and testbench

Single-clock vending controller sequencing coin acceptance, credit accounting, product selection, timed dispense and unit-by-unit change return. It replaces the divided-clock FSM path with a tick-enable scheduler on the system clock and drives the pin-level product/change/ready outputs of the vending top level.

---
 rtl/vending_if.sv | 31 +++
 rtl/vending_sequencer.sv | 157 +++++++++++++++
 tb/tb_vending_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vending_if.sv
// Pin-level handshake and status bundle of the vending controller.
// The master modport drives strobes and the slave modport drives the registered outputs.
interface vending_if;
    logic       ena;
    logic [1:0] coin;
    logic       coin_stb;
    logic [1:0] sel;
    logic       sel_stb;
    logic       cancel;
    logic       refill;

    logic [1:0] producto;
    logic       dispense;
    logic       change_pulse;
    logic       listo;
    logic       reject;
    logic       err;
    logic [3:0] credit;
    logic       busy;
    logic [3:0] empty;

    modport master (
        output ena, coin, coin_stb, sel, sel_stb, cancel, refill,
        input  producto, dispense, change_pulse, listo, reject, err, credit, busy, empty
    );

    modport slave (
        input  ena, coin, coin_stb, sel, sel_stb, cancel, refill,
        output producto, dispense, change_pulse, listo, reject, err, credit, busy, empty
    );
endinterface

// File: rtl/vending_sequencer.sv
// Vending controller: coin/credit accounting, selection, tick-timed dispense and change return.
// All timing runs off a tick enable derived from the system clock.
module vending_sequencer #(
    parameter int TICK_DIV       = 16,
    parameter int DISPENSE_TICKS = 4,
    parameter int STOCK_INIT     = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    vending_if.slave  bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DISPENSE_TICKS > 1) ? $clog2(DISPENSE_TICKS) : 1;

    typedef enum logic [1:0] {IDLE, VEND, CHANGE, DONE} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic          tick;
    logic [DW-1:0] disp_cnt;
    logic [2:0]    stock [4];

    logic [1:0] producto;
    logic       dispense;
    logic       change_pulse;
    logic       listo;
    logic       reject;
    logic       err;
    logic [3:0] credit;
    logic       busy;
    logic [3:0] empty;

    logic       coin_valid;
    logic [4:0] coin_sum;
    logic [3:0] price;
    logic       sel_ok;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign tick       = (presc == PW'(TICK_DIV - 1));
    assign coin_valid = bus.coin_stb && (bus.coin != 2'b00);
    // Coin codes 01/10/11 are worth 2/3/4 units, i.e. code + 1.
    assign coin_sum   = {1'b0, credit} + {3'b000, bus.coin} + 5'd1;
    assign price      = {2'b00, bus.sel} + 4'd3;
    assign sel_ok     = (credit >= price) && (stock[bus.sel] != 3'd0);

    // NOTE: the 4-entry stock array is reset explicitly because it is controller state, not bulk storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            disp_cnt     <= '0;
            for (int i = 0; i < 4; i++) stock[i] <= 3'(STOCK_INIT);
            producto     <= 2'b00;
            dispense     <= 1'b0;
            change_pulse <= 1'b0;
            listo        <= 1'b0;
            reject       <= 1'b0;
            err          <= 1'b0;
            credit       <= 4'd0;
            busy         <= 1'b0;
            empty        <= 4'b0000;
        end else begin
            reject <= 1'b0;
            err    <= 1'b0;
            listo  <= 1'b0;

            // Coins arriving mid-transaction are bounced back to the customer.
            if (bus.ena && coin_valid && state != IDLE) reject <= 1'b1;

            case (state)
                IDLE: begin
                    if (bus.ena) begin
                        if (bus.refill) begin
                            for (int i = 0; i < 4; i++) stock[i] <= 3'(STOCK_INIT);
                            empty <= 4'b0000;
                        end else if (bus.cancel) begin
                            if (credit != 4'd0) begin
                                state <= CHANGE;
                                busy  <= 1'b1;
                            end
                        end else if (bus.sel_stb) begin
                            if (sel_ok) begin
                                credit          <= credit - price;
                                stock[bus.sel]  <= stock[bus.sel] - 3'd1;
                                empty[bus.sel]  <= (stock[bus.sel] == 3'd1);
                                producto        <= bus.sel;
                                dispense        <= 1'b1;
                                disp_cnt        <= '0;
                                state           <= VEND;
                                busy            <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                        end else if (coin_valid) begin
                            if (coin_sum <= 5'd15) credit <= coin_sum[3:0];
                            else                   reject <= 1'b1;
                        end
                        // A valid coin pre-empted by a higher-priority strobe is refused.
                        if (coin_valid && (bus.refill || bus.cancel || bus.sel_stb)) reject <= 1'b1;
                    end
                end

                VEND: begin
                    if (tick) begin
                        if (disp_cnt == DW'(DISPENSE_TICKS - 1)) begin
                            dispense <= 1'b0;
                            if (credit != 4'd0) begin
                                state <= CHANGE;
                            end else begin
                                state <= DONE;
                                listo <= 1'b1;
                            end
                        end else begin
                            disp_cnt <= disp_cnt + 1'b1;
                        end
                    end
                end

                CHANGE: begin
                    if (credit == 4'd0 && !change_pulse) begin
                        state <= DONE;
                        listo <= 1'b1;
                    end else if (tick) begin
                        change_pulse <= ~change_pulse;
                        if (change_pulse) credit <= credit - 4'd1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.producto     = producto;
    assign bus.dispense     = dispense;
    assign bus.change_pulse = change_pulse;
    assign bus.listo        = listo;
    assign bus.reject       = reject;
    assign bus.err          = err;
    assign bus.credit       = credit;
    assign bus.busy         = busy;
    assign bus.empty        = empty;
endmodule

// File: tb/tb_vending_sequencer.sv
// Directed bench for vending_sequencer with TICK_DIV=4, DISPENSE_TICKS=2, STOCK_INIT=3.
// Outputs are sampled on the falling clock edge; strobes are driven for one full cycle.
module tb_vending_sequencer;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    vending_if bus ();

    vending_sequencer #(
        .TICK_DIV       (4),
        .DISPENSE_TICKS (2),
        .STOCK_INIT     (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input bit cs, input logic [1:0] c, input bit ss, input logic [1:0] s,
                         input bit can, input bit rf);
        @(negedge clk);
        bus.coin_stb = cs;
        bus.coin     = c;
        bus.sel_stb  = ss;
        bus.sel      = s;
        bus.cancel   = can;
        bus.refill   = rf;
        @(negedge clk);
        bus.coin_stb = 1'b0;
        bus.sel_stb  = 1'b0;
        bus.cancel   = 1'b0;
        bus.refill   = 1'b0;
    endtask

    task automatic coin(input logic [1:0] c);
        drive(1'b1, c, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic select(input logic [1:0] s);
        drive(1'b0, 2'b00, 1'b1, s, 1'b0, 1'b0);
    endtask

    // Follows a transaction until busy drops, collecting observed timing.
    task automatic run_txn(output int disp_cyc, output int pulses, output int hi_min,
                           output int hi_max, output int listo_cnt, output bit timed_out);
        int run;
        disp_cyc = 0; pulses = 0; hi_min = 1000; hi_max = 0; listo_cnt = 0; run = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (bus.dispense) disp_cyc++;
            if (bus.change_pulse) begin
                run++;
            end else if (run != 0) begin
                pulses++;
                if (run < hi_min) hi_min = run;
                if (run > hi_max) hi_max = run;
                run = 0;
            end
            if (bus.listo) listo_cnt++;
            if (!bus.busy) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        coin(2'b11);
        checks++;
        if (bus.credit !== 4'd4) begin
            errors++; $display("FAIL reset_precoin credit=%0d want 4", bus.credit);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.producto, bus.dispense, bus.change_pulse, bus.listo, bus.reject, bus.err, bus.busy} !== 8'h00) begin
            errors++; $display("FAIL reset_outputs got %b want 00000000",
                {bus.producto, bus.dispense, bus.change_pulse, bus.listo, bus.reject, bus.err, bus.busy});
        end
        checks++;
        if (bus.credit !== 4'd0 || bus.empty !== 4'b0000) begin
            errors++; $display("FAIL reset_credit_empty credit=%0d empty=%b want 0/0000", bus.credit, bus.empty);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vend_change;
        int d, p, lo, hi, l;
        bit to;
        coin(2'b11);
        coin(2'b10);
        checks++;
        if (bus.credit !== 4'd7) begin
            errors++; $display("FAIL vend_credit_in credit=%0d want 7", bus.credit);
        end
        select(2'b01);
        checks++;
        if (bus.producto !== 2'b01 || bus.credit !== 4'd3 || bus.dispense !== 1'b1 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL vend_accept producto=%0d credit=%0d dispense=%b busy=%b want 1/3/1/1",
                bus.producto, bus.credit, bus.dispense, bus.busy);
        end
        run_txn(d, p, lo, hi, l, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL vend_timeout busy stuck high"); end
        checks++;
        if (d < 5 || d > 8) begin errors++; $display("FAIL vend_dispense_width got %0d want 5..8", d); end
        checks++;
        if (p !== 3 || lo !== 4 || hi !== 4) begin
            errors++; $display("FAIL vend_change pulses=%0d width=%0d..%0d want 3 of 4", p, lo, hi);
        end
        checks++;
        if (l !== 1 || bus.credit !== 4'd0) begin
            errors++; $display("FAIL vend_done listo=%0d credit=%0d want 1/0", l, bus.credit);
        end
        // Two further exact-credit P1 vends exhaust a stock that was left at 2.
        for (int k = 0; k < 2; k++) begin
            coin(2'b11);
            select(2'b01);
            run_txn(d, p, lo, hi, l, to);
        end
        checks++;
        if (bus.empty !== 4'b0010 || p !== 0) begin
            errors++; $display("FAIL vend_stock1 empty=%b pulses=%0d want 0010/0", bus.empty, p);
        end
        drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1);
        checks++;
        if (bus.empty !== 4'b0000) begin
            errors++; $display("FAIL vend_refill empty=%b want 0000", bus.empty);
        end
    endtask

    task automatic test_insufficient;
        int d, p, lo, hi, l;
        bit to;
        coin(2'b01);
        select(2'b00);
        checks++;
        if (bus.err !== 1'b1 || bus.credit !== 4'd2 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL insuff_err err=%b credit=%0d busy=%b want 1/2/0", bus.err, bus.credit, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL insuff_err_width err=%b want 0", bus.err); end
        drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0);
        run_txn(d, p, lo, hi, l, to);
        checks++;
        if (to !== 1'b0 || p !== 2 || l !== 1 || d !== 0 || bus.credit !== 4'd0) begin
            errors++; $display("FAIL insuff_cancel to=%b pulses=%0d listo=%0d disp=%0d credit=%0d want 0/2/1/0/0",
                to, p, l, d, bus.credit);
        end
    endtask

    task automatic test_ena;
        bus.ena = 1'b0;
        coin(2'b11);
        checks++;
        if (bus.credit !== 4'd0 || bus.reject !== 1'b0) begin
            errors++; $display("FAIL ena_gate credit=%0d reject=%b want 0/0", bus.credit, bus.reject);
        end
        bus.ena = 1'b1;
    endtask

    task automatic test_saturation_priority;
        int d, p, lo, hi, l;
        bit to;
        for (int k = 0; k < 3; k++) coin(2'b11);
        checks++;
        if (bus.credit !== 4'd12) begin errors++; $display("FAIL sat_credit credit=%0d want 12", bus.credit); end
        coin(2'b11);
        checks++;
        if (bus.reject !== 1'b1 || bus.credit !== 4'd12) begin
            errors++; $display("FAIL sat_reject reject=%b credit=%0d want 1/12", bus.reject, bus.credit);
        end
        drive(1'b1, 2'b11, 1'b1, 2'b11, 1'b0, 1'b0);
        checks++;
        if (bus.reject !== 1'b1 || bus.dispense !== 1'b1 || bus.producto !== 2'b11 || bus.credit !== 4'd6) begin
            errors++; $display("FAIL prio_vend reject=%b dispense=%b producto=%0d credit=%0d want 1/1/3/6",
                bus.reject, bus.dispense, bus.producto, bus.credit);
        end
        run_txn(d, p, lo, hi, l, to);
        checks++;
        if (to !== 1'b0 || p !== 6 || l !== 1 || bus.credit !== 4'd0) begin
            errors++; $display("FAIL prio_refund to=%b pulses=%0d listo=%0d credit=%0d want 0/6/1/0",
                to, p, l, bus.credit);
        end
    endtask

    task automatic test_stock_out;
        int d, p, lo, hi, l;
        bit to;
        drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            coin(2'b11);
            coin(2'b01);
            select(2'b11);
            run_txn(d, p, lo, hi, l, to);
        end
        checks++;
        if (bus.empty !== 4'b1000 || bus.credit !== 4'd0 || to !== 1'b0) begin
            errors++; $display("FAIL stock_empty empty=%b credit=%0d to=%b want 1000/0/0", bus.empty, bus.credit, to);
        end
        coin(2'b11);
        coin(2'b01);
        select(2'b11);
        checks++;
        if (bus.err !== 1'b1 || bus.credit !== 4'd6 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL stock_err err=%b credit=%0d busy=%b want 1/6/0", bus.err, bus.credit, bus.busy);
        end
        drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1);
        checks++;
        if (bus.empty !== 4'b0000 || bus.credit !== 4'd6) begin
            errors++; $display("FAIL stock_refill empty=%b credit=%0d want 0000/6", bus.empty, bus.credit);
        end
        drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0);
        run_txn(d, p, lo, hi, l, to);
        checks++;
        if (to !== 1'b0 || p !== 6 || bus.credit !== 4'd0) begin
            errors++; $display("FAIL stock_cancel to=%b pulses=%0d credit=%0d want 0/6/0", to, p, bus.credit);
        end
    endtask

    task automatic test_reset_mid_vend;
        coin(2'b11);
        coin(2'b10);
        select(2'b00);
        checks++;
        if (bus.dispense !== 1'b1 || bus.credit !== 4'd4) begin
            errors++; $display("FAIL midvend_accept dispense=%b credit=%0d want 1/4", bus.dispense, bus.credit);
        end
        coin(2'b11);
        checks++;
        if (bus.reject !== 1'b1 || bus.credit !== 4'd4 || bus.dispense !== 1'b1) begin
            errors++; $display("FAIL midvend_coin reject=%b credit=%0d dispense=%b want 1/4/1",
                bus.reject, bus.credit, bus.dispense);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.dispense !== 1'b0 || bus.credit !== 4'd0 || bus.busy !== 1'b0 || bus.empty !== 4'b0000) begin
            errors++; $display("FAIL midvend_reset dispense=%b credit=%0d busy=%b empty=%b want 0/0/0/0000",
                bus.dispense, bus.credit, bus.busy, bus.empty);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n        = 1'b0;
        bus.ena      = 1'b1;
        bus.coin     = 2'b00;
        bus.coin_stb = 1'b0;
        bus.sel      = 2'b00;
        bus.sel_stb  = 1'b0;
        bus.cancel   = 1'b0;
        bus.refill   = 1'b0;
        #23 rst_n = 1'b1;

        test_reset();
        test_vend_change();
        test_insufficient();
        test_ena();
        test_saturation_priority();
        test_stock_out();
        test_reset_mid_vend();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
